// File: rtl/seg7_scan_counter.sv
// ---------------------------------------------------------------------------
// seg7_scan_counter
//
// Multi-digit BCD up/down counter with a count prescaler, driving a
// time-multiplexed 7-segment display with optional leading-zero blanking and
// selectable common-anode / common-cathode pin polarity.
//
// Parameters:
//   DIGITS       number of BCD digits (1..8)
//   PRESCALE     clk cycles per count step (>=1)
//   SCAN_DIV     clk cycles each digit stays lit (>=1)
//   BLANK_LZ     1 = blank leading zero digits (digit 0 is never blanked)
//   COMMON_ANODE 1 = seg and dig_sel are active-low
//
// Ports:
//   clk       in   system clock
//   rst       in   asynchronous reset, active low
//   en        in   count enable (freezes prescaler and count when low)
//   up_dn     in   1 = count up, 0 = count down
//   clr       in   synchronous clear (highest priority)
//   load      in   synchronous parallel load
//   load_val  in   BCD load value, digit 0 in bits [3:0]
//   bcd       out  current count in BCD
//   carry     out  one-cycle pulse after a wrap-around edge
//   seg       out  segments {g,f,e,d,c,b,a}
//   dig_sel   out  one-hot digit enable
// ---------------------------------------------------------------------------
module seg7_scan_counter #(
    parameter int DIGITS       = 4,
    parameter int PRESCALE     = 50000000,
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_LZ     = 1,
    parameter int COMMON_ANODE = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  up_dn,
    input  logic                  clr,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  carry,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     dig_sel
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [PW-1:0]     PRESC_MAX = PW'(PRESCALE - 1);
    localparam logic [SW-1:0]     SCAN_MAX  = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0]     IDX_MAX   = IW'(DIGITS - 1);
    localparam logic [6:0]        SEG_ZERO  = 7'b0111111;
    localparam logic [DIGITS-1:0] DIG_FIRST = DIGITS'(1);
    localparam logic              INVERT    = (COMMON_ANODE != 0);

    // Active-high segment pattern for one BCD digit.
    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    seg_code = 7'b0111111;
            4'd1:    seg_code = 7'b0000110;
            4'd2:    seg_code = 7'b1011011;
            4'd3:    seg_code = 7'b1001111;
            4'd4:    seg_code = 7'b1100110;
            4'd5:    seg_code = 7'b1101101;
            4'd6:    seg_code = 7'b1111101;
            4'd7:    seg_code = 7'b0000111;
            4'd8:    seg_code = 7'b1111111;
            4'd9:    seg_code = 7'b1100111;
            default: seg_code = 7'b0000000;
        endcase
    endfunction

    logic [4*DIGITS-1:0] bcd_q;
    logic [PW-1:0]       presc_q;
    logic                carry_q;
    logic [SW-1:0]       scan_cnt_q;
    logic [IW-1:0]       scan_idx_q;
    logic [6:0]          seg_q;
    logic [DIGITS-1:0]   dig_sel_q;

    logic                tick;
    logic [4*DIGITS-1:0] count_next;
    logic                wrap;
    logic                ripple;
    logic [3:0]          digit_cur;
    logic [4*DIGITS-1:0] load_sat;
    logic [DIGITS-1:0]   onehot;
    logic [3:0]          digit_shown;
    logic [DIGITS-1:0]   zero_above;
    logic                zero_acc;
    logic                blank;
    logic [6:0]          seg_next;

    assign tick = en && (presc_q == PRESC_MAX);

    // Ripple increment/decrement across all digits in one cycle; a carry or
    // borrow still pending after the top digit means the counter wrapped.
    always_comb begin
        count_next = bcd_q;
        ripple     = 1'b1;
        digit_cur  = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            digit_cur = bcd_q[i*4 +: 4];
            if (ripple) begin
                if (up_dn) begin
                    if (digit_cur == 4'd9) begin
                        count_next[i*4 +: 4] = 4'd0;
                    end else begin
                        count_next[i*4 +: 4] = digit_cur + 4'd1;
                        ripple = 1'b0;
                    end
                end else begin
                    if (digit_cur == 4'd0) begin
                        count_next[i*4 +: 4] = 4'd9;
                    end else begin
                        count_next[i*4 +: 4] = digit_cur - 4'd1;
                        ripple = 1'b0;
                    end
                end
            end
        end
        wrap = ripple;
    end

    // Non-decimal load nibbles saturate to 9 so bcd always stays valid BCD.
    always_comb begin
        load_sat = '0;
        for (int i = 0; i < DIGITS; i++) begin
            load_sat[i*4 +: 4] = (load_val[i*4 +: 4] > 4'd9) ? 4'd9 : load_val[i*4 +: 4];
        end
    end

    // Count state: clr beats load beats tick; carry only ever comes from a tick.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bcd_q   <= '0;
            presc_q <= '0;
            carry_q <= 1'b0;
        end else if (clr) begin
            bcd_q   <= '0;
            presc_q <= '0;
            carry_q <= 1'b0;
        end else if (load) begin
            bcd_q   <= load_sat;
            presc_q <= '0;
            carry_q <= 1'b0;
        end else begin
            carry_q <= 1'b0;
            if (tick) begin
                presc_q <= '0;
                bcd_q   <= count_next;
                carry_q <= wrap;
            end else if (en) begin
                presc_q <= presc_q + PW'(1);
            end
        end
    end

    // Free-running scan timebase, unaffected by en, clr and load.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scan_cnt_q <= '0;
            scan_idx_q <= '0;
        end else if (scan_cnt_q == SCAN_MAX) begin
            scan_cnt_q <= '0;
            scan_idx_q <= (scan_idx_q == IDX_MAX) ? '0 : scan_idx_q + IW'(1);
        end else begin
            scan_cnt_q <= scan_cnt_q + SW'(1);
        end
    end

    // Select the scanned digit; zero_above[k] is set when digit k and every
    // digit above it are zero, which is exactly the leading-zero condition.
    always_comb begin
        onehot      = '0;
        digit_shown = 4'd0;
        zero_above  = '0;
        zero_acc    = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (scan_idx_q == IW'(i)) begin
                onehot[i]   = 1'b1;
                digit_shown = bcd_q[i*4 +: 4];
            end
        end
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_acc      = zero_acc && (bcd_q[i*4 +: 4] == 4'd0);
            zero_above[i] = zero_acc;
        end
        blank    = (BLANK_LZ != 0) && (scan_idx_q != '0) && (|(onehot & zero_above));
        seg_next = blank ? 7'b0000000 : seg_code(digit_shown);
    end

    // seg and dig_sel are registered together from the same scan index so a
    // digit enable is never paired with another digit's segment pattern.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seg_q     <= INVERT ? ~SEG_ZERO : SEG_ZERO;
            dig_sel_q <= INVERT ? ~DIG_FIRST : DIG_FIRST;
        end else begin
            seg_q     <= INVERT ? ~seg_next : seg_next;
            dig_sel_q <= INVERT ? ~onehot : onehot;
        end
    end

    assign bcd     = bcd_q;
    assign carry   = carry_q;
    assign seg     = seg_q;
    assign dig_sel = dig_sel_q;

endmodule
